// File: rtl/pio_pkg.sv
// ---------------------------------------------------------------------------
// pio_pkg
// Shared constants for the pio_out_blink_irq parallel I/O slave:
//   - word addresses of the eight registers in the slave's address window
//   - encodings of the EDGE_TYPE parameter (capture edge selection)
// ---------------------------------------------------------------------------
package pio_pkg;

   // Register word addresses
   localparam logic [2:0] ADDR_DATA      = 3'd0;
   localparam logic [2:0] ADDR_IN        = 3'd1;
   localparam logic [2:0] ADDR_SET       = 3'd2;
   localparam logic [2:0] ADDR_CLR       = 3'd3;
   localparam logic [2:0] ADDR_MASK      = 3'd4;
   localparam logic [2:0] ADDR_EDGE      = 3'd5;
   localparam logic [2:0] ADDR_BLINK_EN  = 3'd6;
   localparam logic [2:0] ADDR_BLINK_DIV = 3'd7;

   // EDGE_TYPE encodings
   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

endpackage : pio_pkg

// File: rtl/pio_blink_gen.sv
// ---------------------------------------------------------------------------
// pio_blink_gen
// Blink prescaler: counts cnt from 0 up to div, then wraps to 0 and toggles
// phase, giving a square wave of period 2*(div+1) cycles. A restart pulse
// (issued when the divider register is written) clears cnt and phase, so
// the blink pattern always restarts in its "on" half.
//
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous, active-low reset
//   div      in   DIV_WIDTH  wrap value (current BLINK_DIV register)
//   restart  in   1          clear counter and phase this edge
//   phase    out  1          0 = blinking bits shown, 1 = blinking bits dark
// ---------------------------------------------------------------------------
module pio_blink_gen #(
   parameter int DIV_WIDTH = 24
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [DIV_WIDTH-1:0] div,
   input  logic                 restart,
   output logic                 phase
);

   logic [DIV_WIDTH-1:0] cnt_reg;
   logic [DIV_WIDTH-1:0] cnt_next;
   logic                 phase_reg;
   logic                 phase_next;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_reg   <= '0;
         phase_reg <= 1'b0;
      end else begin
         cnt_reg   <= cnt_next;
         phase_reg <= phase_next;
      end
   end

   // Equality compare against div: a rewrite of div always comes with a
   // restart, so cnt can never sit above div and run a long wrap.
   always_comb begin
      cnt_next   = cnt_reg;
      phase_next = phase_reg;
      if (restart) begin
         cnt_next   = '0;
         phase_next = 1'b0;
      end else if (cnt_reg == div) begin
         cnt_next   = '0;
         phase_next = ~phase_reg;
      end else begin
         cnt_next   = cnt_reg + 1'b1;
      end
   end

   assign phase = phase_reg;

endmodule : pio_blink_gen

// File: rtl/pio_out_blink_irq.sv
// ---------------------------------------------------------------------------
// pio_out_blink_irq
// Avalon-MM parallel I/O slave: WIDTH-bit output register with atomic
// set/clear, synchronised input port with edge capture and masked level
// interrupt, and an optional per-bit blink engine. Reads are zero-wait,
// combinational on address, without side effects.
//
// Build option: define PIO_BLINK_EN to implement the blink engine
// (BLINK_EN / BLINK_DIV registers, pio_blink_gen). Without it addresses 6
// and 7 read 0 and ignore writes, and out_port = DATA.
//
// Ports:
//   clk         in   1      system clock
//   reset_n     in   1      asynchronous, active-low reset
//   address     in   3      word address
//   chipselect  in   1      slave select
//   write_n     in   1      active-low write strobe
//   writedata   in   32     write data (bits above WIDTH ignored)
//   readdata    out  32     read data (bits above WIDTH read 0)
//   in_port     in   WIDTH  asynchronous external inputs
//   out_port    out  WIDTH  driven outputs
//   irq         out  1      level interrupt, |(EDGE & MASK)
// ---------------------------------------------------------------------------
module pio_out_blink_irq
   import pio_pkg::*;
#(
   parameter int               WIDTH       = 18,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter int               EDGE_TYPE   = EDGE_RISE,
   parameter int               DIV_WIDTH   = 24
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] out_port,
   output logic             irq
);

   logic             wr_en;
   logic [WIDTH-1:0] wd;

   logic [WIDTH-1:0] data_reg;
   logic [WIDTH-1:0] data_next;
   logic [WIDTH-1:0] mask_reg;
   logic [WIDTH-1:0] mask_next;
   logic [WIDTH-1:0] edge_reg;
   logic [WIDTH-1:0] edge_next;
   logic [WIDTH-1:0] edge_clr;
   logic [WIDTH-1:0] edge_cond;

   logic [WIDTH-1:0] in_meta_reg;
   logic [WIDTH-1:0] in_sync_reg;
   logic [WIDTH-1:0] in_prev_reg;
   // Fills with ones after reset; bit 2 says in_prev holds a real sample.
   logic [2:0]       prime_reg;

   logic             unused_bits;

   assign wr_en = chipselect & ~write_n;
   assign wd    = writedata[WIDTH-1:0];

   // Upper writedata bits are deliberately ignored.
   assign unused_bits = (^writedata) ^ (DIV_WIDTH == 0);

   // ------------------------------------------------------------------
   // Input synchroniser, previous-sample flop and priming shifter
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         in_meta_reg <= '0;
         in_sync_reg <= '0;
         in_prev_reg <= '0;
         prime_reg   <= '0;
      end else begin
         in_meta_reg <= in_port;
         in_sync_reg <= in_meta_reg;
         in_prev_reg <= in_sync_reg;
         prime_reg   <= {prime_reg[1:0], 1'b1};
      end
   end

   // Edge detection per bit. Until the pipeline has refilled after reset,
   // the reset-zero in_prev would turn any pin already high into a fake
   // edge, so capture is held off until in_prev carries a real sample.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_edge
         if (EDGE_TYPE == EDGE_FALL) begin : g_fall
            assign edge_cond[gi] = prime_reg[2] & ~in_sync_reg[gi] & in_prev_reg[gi];
         end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
            assign edge_cond[gi] = prime_reg[2] & (in_sync_reg[gi] ^ in_prev_reg[gi]);
         end else begin : g_rise
            assign edge_cond[gi] = prime_reg[2] & in_sync_reg[gi] & ~in_prev_reg[gi];
         end
      end
   endgenerate

   // ------------------------------------------------------------------
   // Core registers: DATA, MASK, EDGE
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_reg <= RESET_VALUE;
         mask_reg <= '0;
         edge_reg <= '0;
      end else begin
         data_reg <= data_next;
         mask_reg <= mask_next;
         edge_reg <= edge_next;
      end
   end

   always_comb begin
      data_next = data_reg;
      mask_next = mask_reg;
      edge_clr  = '0;
      if (wr_en) begin
         case (address)
            ADDR_DATA: data_next = wd;
            ADDR_SET:  data_next = data_reg | wd;
            ADDR_CLR:  data_next = data_reg & ~wd;
            ADDR_MASK: mask_next = wd;
            ADDR_EDGE: edge_clr  = wd;
            default:   ;
         endcase
      end
      // A fresh edge outranks a simultaneous write-1-to-clear.
      edge_next = (edge_reg & ~edge_clr) | edge_cond;
   end

   assign irq = |(edge_reg & mask_reg);

   // ------------------------------------------------------------------
   // Optional blink engine
   // ------------------------------------------------------------------
`ifdef PIO_BLINK_EN
   logic [WIDTH-1:0]     blink_en_reg;
   logic [WIDTH-1:0]     blink_en_next;
   logic [DIV_WIDTH-1:0] blink_div_reg;
   logic [DIV_WIDTH-1:0] blink_div_next;
   logic                 div_wr;
   logic                 phase;

   assign div_wr = wr_en && (address == ADDR_BLINK_DIV);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         blink_en_reg  <= '0;
         blink_div_reg <= '0;
      end else begin
         blink_en_reg  <= blink_en_next;
         blink_div_reg <= blink_div_next;
      end
   end

   always_comb begin
      blink_en_next  = blink_en_reg;
      blink_div_next = blink_div_reg;
      if (wr_en && (address == ADDR_BLINK_EN)) begin
         blink_en_next = wd;
      end
      if (div_wr) begin
         blink_div_next = writedata[DIV_WIDTH-1:0];
      end
   end

   pio_blink_gen #(
      .DIV_WIDTH (DIV_WIDTH)
   ) u_blink_gen (
      .clk     (clk),
      .reset_n (reset_n),
      .div     (blink_div_reg),
      .restart (div_wr),
      .phase   (phase)
   );

   assign out_port = data_reg & ~(blink_en_reg & {WIDTH{phase}});
`else
   assign out_port = data_reg;
`endif

   // ------------------------------------------------------------------
   // Read mux: zero-extended, write-only and absent registers read 0
   // ------------------------------------------------------------------
   always_comb begin
      readdata = '0;
      case (address)
         ADDR_DATA:      readdata[WIDTH-1:0] = data_reg;
         ADDR_IN:        readdata[WIDTH-1:0] = in_sync_reg;
         ADDR_MASK:      readdata[WIDTH-1:0] = mask_reg;
         ADDR_EDGE:      readdata[WIDTH-1:0] = edge_reg;
`ifdef PIO_BLINK_EN
         ADDR_BLINK_EN:  readdata[WIDTH-1:0] = blink_en_reg;
         ADDR_BLINK_DIV: readdata[DIV_WIDTH-1:0] = blink_div_reg;
`endif
         default:        readdata = '0;
      endcase
   end

endmodule : pio_out_blink_irq

// File: tb/tb_pio_out_blink_irq.sv
// ---------------------------------------------------------------------------
// tb_pio_out_blink_irq
// Directed self-checking bench for pio_out_blink_irq (WIDTH=18,
// RESET_VALUE=0x11, rising-edge capture). Inputs are driven on the falling
// clock edge; outputs are checked there too, away from the active edge.
// Blink checks are compiled when PIO_BLINK_EN is defined, otherwise the
// bench checks that addresses 6/7 are inert and out_port follows DATA.
// ---------------------------------------------------------------------------
module tb_pio_out_blink_irq;

   localparam int          W  = 18;
   localparam logic [W-1:0] RV = 18'h00011;

   logic          clk;
   logic          reset_n;
   logic [2:0]    address;
   logic          chipselect;
   logic          write_n;
   logic [31:0]   writedata;
   logic [31:0]   readdata;
   logic [W-1:0]  in_port;
   logic [W-1:0]  out_port;
   logic          irq;

   int tests = 0;
   int fails = 0;

   pio_out_blink_irq #(
      .WIDTH       (W),
      .RESET_VALUE (RV),
      .EDGE_TYPE   (0),
      .DIV_WIDTH   (24)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .in_port    (in_port),
      .out_port   (out_port),
      .irq        (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h required %h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
      $display("[TB] write addr=%0d data=%h", a, d);
   endtask

   task automatic read_check(input logic [2:0] a, input logic [31:0] exp, input string tag);
      address    = a;
      chipselect = 1'b1;
      write_n    = 1'b1;
      #1;
      $display("[TB] read addr=%0d data=%h (%s)", a, readdata, tag);
      check(tag, readdata, exp);
      chipselect = 1'b0;
   endtask

   initial begin
      reset_n    = 1'b0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      address    = 3'd0;
      writedata  = 32'h0;
      in_port    = '0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_out_port", 32'(out_port), 32'h00011);
      check("rst_irq", 32'(irq), 32'h0);
      read_check(3'd0, 32'h00011, "rst_data");
      read_check(3'd4, 32'h0, "rst_mask");
      read_check(3'd5, 32'h0, "rst_edge");
      reset_n = 1'b1;
      @(negedge clk);

      // DATA write, upper writedata bits ignored, write-only reads 0
      bus_write(3'd0, 32'hFFF2_A5A5);
      check("data_out_port", 32'(out_port), 32'h0002A5A5);
      read_check(3'd0, 32'h0002A5A5, "data_read");
      read_check(3'd2, 32'h0, "set_reads_0");
      read_check(3'd3, 32'h0, "clr_reads_0");

      // Atomic set / clear
      bus_write(3'd0, 32'h000000F0);
      bus_write(3'd2, 32'h0000000F);
      check("set_out_port", 32'(out_port), 32'h000000FF);
      read_check(3'd0, 32'h000000FF, "set_data");
      bus_write(3'd3, 32'h00000030);
      check("clr_out_port", 32'(out_port), 32'h000000CF);
      read_check(3'd0, 32'h000000CF, "clr_data");

      // Rising edge on bit 0 with MASK=1: IN after 2 cycles, EDGE/irq after 3
      bus_write(3'd4, 32'h1);
      read_check(3'd4, 32'h1, "mask_read");
      in_port = 18'h00001;
      @(negedge clk);
      read_check(3'd1, 32'h0, "in_lat1");
      @(negedge clk);
      read_check(3'd1, 32'h1, "in_lat2");
      read_check(3'd5, 32'h0, "edge_lat2");
      check("irq_lat2", 32'(irq), 32'h0);
      @(negedge clk);
      read_check(3'd5, 32'h1, "edge_lat3");
      check("irq_lat3", 32'(irq), 32'h1);
      bus_write(3'd5, 32'h1);
      check("irq_cleared", 32'(irq), 32'h0);
      read_check(3'd5, 32'h0, "edge_cleared");

      // Falling edge does not capture in rising mode
      in_port = 18'h00000;
      repeat (4) @(negedge clk);
      read_check(3'd5, 32'h0, "fall_no_edge");
      check("fall_no_irq", 32'(irq), 32'h0);

      // Rising edge on bit 3 colliding with a write-1-to-clear: set wins
      in_port = 18'h00008;
      @(negedge clk);
      @(negedge clk);
      address    = 3'd5;
      writedata  = 32'h8;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
      $display("[TB] write addr=5 data=00000008 (on capture edge)");
      read_check(3'd5, 32'h8, "set_wins");
      check("masked_irq", 32'(irq), 32'h0);
      bus_write(3'd5, 32'h8);
      read_check(3'd5, 32'h0, "bit3_cleared");

      // Blink engine (or its absence)
`ifdef PIO_BLINK_EN
      bus_write(3'd0, 32'h3);
      bus_write(3'd6, 32'h1);
      bus_write(3'd7, 32'h4);
      for (int n = 0; n < 20; n++) begin
         check($sformatf("blink_%0d", n), 32'(out_port), ((n / 5) % 2 == 0) ? 32'h3 : 32'h2);
         @(negedge clk);
      end
      read_check(3'd6, 32'h1, "blink_en_read");
      read_check(3'd7, 32'h4, "blink_div_read");
      repeat (6) @(negedge clk);
      // Now in the dark half; rewriting BLINK_DIV restarts with the bit on
      bus_write(3'd7, 32'h4);
      for (int n = 0; n < 10; n++) begin
         check($sformatf("restart_%0d", n), 32'(out_port), ((n / 5) % 2 == 0) ? 32'h3 : 32'h2);
         @(negedge clk);
      end
`else
      bus_write(3'd6, 32'h1);
      read_check(3'd6, 32'h0, "noblink_en_read");
      bus_write(3'd7, 32'h4);
      read_check(3'd7, 32'h0, "noblink_div_read");
      bus_write(3'd0, 32'h3);
      for (int n = 0; n < 6; n++) begin
         check($sformatf("noblink_out_%0d", n), 32'(out_port), 32'h3);
         @(negedge clk);
      end
`endif

      // Get irq high, then reset asynchronously mid-operation
      bus_write(3'd0, 32'h3FFFF);
      in_port = 18'h00009;
      repeat (3) @(negedge clk);
      check("pre_reset_irq", 32'(irq), 32'h1);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_rst_out", 32'(out_port), 32'h00011);
      check("async_rst_irq", 32'(irq), 32'h0);
      read_check(3'd5, 32'h0, "async_rst_edge");
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      read_check(3'd1, 32'h0, "post_rst_in1");
      @(negedge clk);
      read_check(3'd1, 32'h9, "post_rst_in2");
      repeat (4) @(negedge clk);
      read_check(3'd5, 32'h0, "no_spurious_edge");
      check("no_spurious_irq", 32'(irq), 32'h0);
      read_check(3'd0, 32'h00011, "post_rst_data");
      check("post_rst_out", 32'(out_port), 32'h00011);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_pio_out_blink_irq

// File: doc/pio_out_blink_irq.md
# pio_out_blink_irq

Parametrised Avalon-MM parallel I/O slave, successor to the fixed 18-bit LED output port. It provides a WIDTH-bit output register with atomic set/clear, a synchronised input port with edge capture and a masked level interrupt, and an optional per-bit hardware blink engine. It sits on the Nios II data master's interconnect, driving board LEDs and sampling keys and switches, with zero-wait-state reads.

## Interface
- WIDTH, 18: output and input port width, 1..32.
- RESET_VALUE, 0: reset value of the output data register.
- EDGE_TYPE, 0: capture edge (0 rising, 1 falling, 2 any).
- DIV_WIDTH, 24: blink prescaler width, 1..32.

- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  3  word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data; bits above WIDTH are ignored
- readdata  out  32  read data; bits above WIDTH read 0
- in_port  in  WIDTH  asynchronous external inputs
- out_port  out  WIDTH  driven outputs
- irq  out  1  level interrupt, active-high

## Operation
- A write occurs when chipselect=1 and write_n=0. Reads are combinational on address; there are no read side effects.
- Register map:
  - 0 DATA: read/write output register.
  - 1 IN: read-only synchronised input.
  - 2 SET: write-only, DATA |= wd.
  - 3 CLR: write-only, DATA &= ~wd.
  - 4 MASK: irq mask.
  - 5 EDGE: edge capture; read, or write 1 to clear.
  - 6 BLINK_EN: per-bit blink enable.
  - 7 BLINK_DIV: blink prescaler value.
- Write-only registers read 0.
- Input path: 2-flop synchroniser into in_sync, then a third flop in_prev. The edge condition per bit follows EDGE_TYPE, computed from in_sync and in_prev.
- Edge capture: a bit sets on its edge condition and clears on write-1 to EDGE. When a set and a clear hit the same bit in the same cycle, the set wins.
- irq = |(EDGE & MASK). irq is registered-free combinational from registers.
- Blink engine:
  - Counter cnt counts 0..BLINK_DIV, then wraps to 0 and toggles phase.
  - BLINK_DIV=0 toggles phase every cycle.
  - A write to BLINK_DIV clears cnt and phase in the same cycle.
- out_port = DATA & ~(BLINK_EN & {WIDTH{phase}}). An enabled bit whose DATA bit is 1 alternates on/off, starting on.

## Timing
- Reset values: DATA=RESET_VALUE, out_port=RESET_VALUE, MASK=0, EDGE=0, BLINK_EN=0, BLINK_DIV=0, cnt=0, phase=0, synchroniser flops=0, irq=0.
- Register writes take effect at the clock edge ending the write cycle. out_port and irq reflect them in the following cycle.
- Input latency: a pin change appears in IN 2 cycles later and in EDGE 3 cycles later. irq asserts in the same cycle EDGE sets.
- Blink period is 2*(BLINK_DIV+1) cycles. cnt wraps at BLINK_DIV using DIV_WIDTH-bit unsigned compare.
- When BLINK_DIV is rewritten below the current cnt, the rewrite resets cnt, so there is no long wrap.
- Reset asserted mid-operation returns all state to reset values immediately, with asynchronous assertion. Reset deassertion is synchronised externally.

## Configuration
- PIO_BLINK_EN defined: the blink counter, phase, BLINK_EN and BLINK_DIV are implemented as above.
- PIO_BLINK_EN undefined:
  - Addresses 6 and 7 read 0 and ignore writes.
  - out_port = DATA.
  - No counter logic is synthesised.

## Structure
- Shared package pio_pkg holds:
  - address constants ADDR_DATA..ADDR_BLINK_DIV.
  - EDGE_TYPE encodings EDGE_RISE/EDGE_FALL/EDGE_ANY.
- One sub-module, pio_blink_gen (prescaler counter and phase), instantiated only under PIO_BLINK_EN.

## Test plan
- Reset then write DATA=0x2A5A5 -> out_port=0x2A5A5 the next cycle; read DATA returns 0x0002A5A5; read SET returns 0.
- From DATA=0x00F0, write SET=0x000F then CLR=0x0030 -> DATA=0x00FF, then 0x00CF. Reading DATA with address 0 returns 0x000000CF.
- EDGE_TYPE=0, MASK=0x1, rising edge on in_port[0] -> EDGE[0]=1 and irq=1 three cycles later. Write EDGE=0x1 -> irq=0. A falling edge on the same bit does not set it.
- Rising edge on in_port[3] coinciding with a write EDGE=0x8 on the capture cycle -> EDGE[3] stays 1.
- PIO_BLINK_EN, DATA=0x3, BLINK_EN=0x1, BLINK_DIV=4 -> out_port[0] toggles every 5 cycles (period 10) and out_port[1] stays 1. A write of BLINK_DIV restarts the pattern with the bit on.
- Assert reset_n mid-blink with irq high -> out_port=RESET_VALUE and irq=0 immediately. After release, IN shows the current in_port after 2 cycles, with no spurious edge capture.
